// File: rtl/pll_spi_pkg.sv
// pll_spi_pkg: shared types and helpers for the PLL/synthesiser SPI loader.
//   state_e      - sequencer states of pll_spi_loader
//   MAX_REGS     - widest register bank the next-word search supports
//   min1_clog2   - clog2 clamped to at least 1 bit (counter/index widths)
//   hsb_below    - highest set mask bit strictly below a given index
package pll_spi_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SHIFT_LO    = 3'd1,
    SHIFT_HI    = 3'd2,
    LATCH_SETUP = 3'd3,
    LATCH       = 3'd4,
    GAP         = 3'd5
  } state_e;

  // Upper bound on NUM_REGS for the priority search below.
  localparam int MAX_REGS = 64;

  // Width of a counter/index that must hold values 0..n-1, never zero bits.
  function automatic int min1_clog2(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Highest index i < below with mask[i] set; -1 when there is none.
  // Scanning upwards lets the last hit win, which is the highest one.
  function automatic int hsb_below(input logic [MAX_REGS-1:0] mask, input int below);
    int r;
    r = -1;
    for (int i = 0; i < MAX_REGS; i++) begin
      r = ((i < below) && mask[i]) ? i : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// spi_word_shifter: serialises one REG_WIDTH word MSB-first.
//   clk_i/rst_i   - clock, asynchronous active-high reset
//   start_i       - load word_i; the first bit is on data_o the next cycle
//   word_i        - word to shift
//   sclk_o        - serial clock, low half then high half, CLK_DIV cycles each
//   data_o        - serial data, changes only when sclk_o falls; 0 when idle
//   half_end_o    - last cycle of the current half-period
//   done_o        - last cycle of the final high half (word complete)
module spi_word_shifter
  import pll_spi_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [REG_WIDTH-1:0] word_i,
  output logic                 sclk_o,
  output logic                 data_o,
  output logic                 half_end_o,
  output logic                 done_o
);

  localparam int BW = min1_clog2(REG_WIDTH);
  localparam int TW = min1_clog2(CLK_DIV);

  logic                 active_q, active_d;
  logic                 hi_q, hi_d;
  logic                 sclk_q, sclk_d;
  logic                 data_q, data_d;
  logic [REG_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 half_end_s;
  logic                 last_bit_s;

  // Bit/half-period sequencing; shreg holds the bits not yet presented.
  always_comb begin
    active_d   = active_q;
    hi_d       = hi_q;
    sclk_d     = sclk_q;
    data_d     = data_q;
    shreg_d    = shreg_q;
    bcnt_d     = bcnt_q;
    tcnt_d     = tcnt_q;
    half_end_s = active_q && (tcnt_q == TW'(CLK_DIV - 1));
    last_bit_s = (bcnt_q == BW'(REG_WIDTH - 1));
    if (start_i) begin
      active_d = 1'b1;
      hi_d     = 1'b0;
      sclk_d   = 1'b0;
      data_d   = word_i[REG_WIDTH-1];
      shreg_d  = {word_i[REG_WIDTH-2:0], 1'b0};
      bcnt_d   = '0;
      tcnt_d   = '0;
    end else if (half_end_s) begin
      tcnt_d = '0;
      if (!hi_q) begin
        hi_d   = 1'b1;
        sclk_d = 1'b1;
      end else if (last_bit_s) begin
        // Word finished: park SClk and Data low for the latch setup.
        active_d = 1'b0;
        hi_d     = 1'b0;
        sclk_d   = 1'b0;
        data_d   = 1'b0;
        bcnt_d   = '0;
      end else begin
        hi_d    = 1'b0;
        sclk_d  = 1'b0;
        data_d  = shreg_q[REG_WIDTH-1];
        shreg_d = {shreg_q[REG_WIDTH-2:0], 1'b0};
        bcnt_d  = bcnt_q + BW'(1);
      end
    end else if (active_q) begin
      tcnt_d = tcnt_q + TW'(1);
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      hi_q     <= 1'b0;
      sclk_q   <= 1'b0;
      data_q   <= 1'b0;
      shreg_q  <= '0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      active_q <= active_d;
      hi_q     <= hi_d;
      sclk_q   <= sclk_d;
      data_q   <= data_d;
      shreg_q  <= shreg_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign data_o     = data_q;
  assign half_end_o = half_end_s;
  assign done_o     = half_end_s && hi_q && last_bit_s;

endmodule

// File: rtl/pll_spi_loader.sv
// pll_spi_loader: generic register-bank SPI programmer for PLL chips.
//   ipClk, ipReset        - clock, asynchronous active-high reset
//   ipRegData             - NUM_REGS words; word i at [i*REG_WIDTH +: REG_WIDTH]
//   ipWriteMask, ipUpdate - words to write, single-cycle request
//   opBusy, opDone        - sequence in progress, one-cycle completion pulse
//   opSPI_SClk/Data/Latch - SPI to the chip (mode 0, LE pulse per word)
//   ipMuxOut, opLocked    - chip lock detect in, synchronised copy out
// Masked words go out highest index first. Updates arriving while busy are
// merged into one pending rerun that snapshots ipRegData when it starts.
module pll_spi_loader
  import pll_spi_pkg::*;
#(
  parameter int NUM_REGS     = 8,
  parameter int REG_WIDTH    = 32,
  parameter int CLK_DIV      = 2,
  parameter int LATCH_CYCLES = 2
) (
  input  logic                          ipClk,
  input  logic                          ipReset,
  input  logic [NUM_REGS*REG_WIDTH-1:0] ipRegData,
  input  logic [NUM_REGS-1:0]           ipWriteMask,
  input  logic                          ipUpdate,
  output logic                          opBusy,
  output logic                          opDone,
  output logic                          opSPI_SClk,
  output logic                          opSPI_Data,
  output logic                          opSPI_Latch,
  input  logic                          ipMuxOut,
  output logic                          opLocked
);

  localparam int IDX_W = min1_clog2(NUM_REGS);
  localparam int TW    = min1_clog2((CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES);

  state_e                        state_q, state_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          latch_q, latch_d;
  logic [TW-1:0]                 tcnt_q, tcnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NUM_REGS*REG_WIDTH-1:0] snap_data_q, snap_data_d;
  logic [NUM_REGS-1:0]           snap_mask_q, snap_mask_d;
  logic                          pend_q, pend_d;
  logic [NUM_REGS-1:0]           pend_mask_q, pend_mask_d;
  logic                          sync1_q, sync2_q;

  logic                          upd_valid_s;
  logic                          eff_pend_s;
  logic [NUM_REGS-1:0]           eff_mask_s;
  int                            accept_idx_s;
  int                            next_idx_s;
  int                            rerun_idx_s;
  logic                          sh_start_s;
  logic [REG_WIDTH-1:0]          sh_word_s;
  logic                          sh_half_end_s;
  logic                          sh_done_s;

  function automatic logic [MAX_REGS-1:0] ext_mask(input logic [NUM_REGS-1:0] m);
    logic [MAX_REGS-1:0] r;
    r = '0;
    r[NUM_REGS-1:0] = m;
    return r;
  endfunction

  // Word i of a bank as a plain mux, so an index of -1 simply yields zero.
  function automatic logic [REG_WIDTH-1:0] word_at(input logic [NUM_REGS*REG_WIDTH-1:0] bank,
                                                   input int i);
    logic [REG_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      r = (k == i) ? bank[k*REG_WIDTH +: REG_WIDTH] : r;
    end
    return r;
  endfunction

  spi_word_shifter #(
    .REG_WIDTH (REG_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) u_shifter (
    .clk_i      (ipClk),
    .rst_i      (ipReset),
    .start_i    (sh_start_s),
    .word_i     (sh_word_s),
    .sclk_o     (opSPI_SClk),
    .data_o     (opSPI_Data),
    .half_end_o (sh_half_end_s),
    .done_o     (sh_done_s)
  );

  // Pending view including an update landing this very cycle, plus word searches.
  always_comb begin
    upd_valid_s = ipUpdate && (ipWriteMask != '0);
    if (busy_q && upd_valid_s) begin
      eff_pend_s = 1'b1;
      eff_mask_s = pend_mask_q | ipWriteMask;
    end else begin
      eff_pend_s = pend_q;
      eff_mask_s = pend_mask_q;
    end
    accept_idx_s = hsb_below(ext_mask(ipWriteMask), NUM_REGS);
    next_idx_s   = hsb_below(ext_mask(snap_mask_q), int'(idx_q));
    rerun_idx_s  = hsb_below(ext_mask(eff_mask_s), NUM_REGS);
  end

  // Sequencer next state: word selection, latch/gap timing, rerun and completion.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    latch_d     = 1'b0;
    tcnt_d      = tcnt_q;
    idx_d       = idx_q;
    snap_data_d = snap_data_q;
    snap_mask_d = snap_mask_q;
    pend_d      = eff_pend_s;
    pend_mask_d = eff_mask_s;
    sh_start_s  = 1'b0;
    sh_word_s   = '0;
    case (state_q)
      IDLE: begin
        if (upd_valid_s) begin
          snap_data_d = ipRegData;
          snap_mask_d = ipWriteMask;
          idx_d       = IDX_W'(accept_idx_s);
          sh_start_s  = 1'b1;
          sh_word_s   = word_at(ipRegData, accept_idx_s);
          state_d     = SHIFT_LO;
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT_LO: begin
        if (sh_half_end_s) begin
          state_d = SHIFT_HI;
        end else begin
          state_d = SHIFT_LO;
        end
      end
      SHIFT_HI: begin
        if (sh_done_s) begin
          state_d = LATCH_SETUP;
          tcnt_d  = '0;
        end else if (sh_half_end_s) begin
          state_d = SHIFT_LO;
        end else begin
          state_d = SHIFT_HI;
        end
      end
      LATCH_SETUP: begin
        if (tcnt_q == TW'(CLK_DIV - 1)) begin
          state_d = LATCH;
          tcnt_d  = '0;
          latch_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      LATCH: begin
        if (tcnt_q == TW'(LATCH_CYCLES - 1)) begin
          state_d = GAP;
          tcnt_d  = '0;
          latch_d = 1'b0;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
          latch_d = 1'b1;
        end
      end
      GAP: begin
        if (tcnt_q == TW'(CLK_DIV - 1)) begin
          tcnt_d = '0;
          if (next_idx_s >= 0) begin
            idx_d      = IDX_W'(next_idx_s);
            sh_start_s = 1'b1;
            sh_word_s  = word_at(snap_data_q, next_idx_s);
            state_d    = SHIFT_LO;
          end else if (eff_pend_s) begin
            // Rerun back-to-back with fresh data; opBusy never drops.
            snap_data_d = ipRegData;
            snap_mask_d = eff_mask_s;
            idx_d       = IDX_W'(rerun_idx_s);
            sh_start_s  = 1'b1;
            sh_word_s   = word_at(ipRegData, rerun_idx_s);
            pend_d      = 1'b0;
            pend_mask_d = '0;
            state_d     = SHIFT_LO;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        tcnt_d      = '0;
        pend_d      = 1'b0;
        pend_mask_d = '0;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      latch_q     <= 1'b0;
      tcnt_q      <= '0;
      idx_q       <= '0;
      snap_data_q <= '0;
      snap_mask_q <= '0;
      pend_q      <= 1'b0;
      pend_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      latch_q     <= latch_d;
      tcnt_q      <= tcnt_d;
      idx_q       <= idx_d;
      snap_data_q <= snap_data_d;
      snap_mask_q <= snap_mask_d;
      pend_q      <= pend_d;
      pend_mask_q <= pend_mask_d;
    end
  end

  // Two-flop synchroniser for the asynchronous MuxOut lock-detect line.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ipMuxOut;
      sync2_q <= sync1_q;
    end
  end

  assign opBusy      = busy_q;
  assign opDone      = done_q;
  assign opSPI_Latch = latch_q;
  assign opLocked    = sync2_q;

endmodule

// File: tb/tb_pll_spi_loader.sv
// tb_pll_spi_loader: directed self-checking bench for pll_spi_loader.
// Instance A uses the default parameters; instance B is the small
// NUM_REGS=3 / REG_WIDTH=24 / CLK_DIV=1 / LATCH_CYCLES=1 configuration.
module tb_pll_spi_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mux_in = 1'b0;

  logic [255:0] a_bank = '0;
  logic [7:0]   a_mask = '0;
  logic         a_upd = 1'b0;
  logic         a_busy, a_done, a_sclk, a_data, a_latch, a_locked;

  logic [71:0]  b_bank = '0;
  logic [2:0]   b_mask = '0;
  logic         b_upd = 1'b0;
  logic         b_busy, b_done, b_sclk, b_data, b_latch, b_locked;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pll_spi_loader dut_a (
    .ipClk (clk), .ipReset (rst), .ipRegData (a_bank), .ipWriteMask (a_mask),
    .ipUpdate (a_upd), .opBusy (a_busy), .opDone (a_done), .opSPI_SClk (a_sclk),
    .opSPI_Data (a_data), .opSPI_Latch (a_latch), .ipMuxOut (mux_in), .opLocked (a_locked)
  );

  pll_spi_loader #(.NUM_REGS(3), .REG_WIDTH(24), .CLK_DIV(1), .LATCH_CYCLES(1)) dut_b (
    .ipClk (clk), .ipReset (rst), .ipRegData (b_bank), .ipWriteMask (b_mask),
    .ipUpdate (b_upd), .opBusy (b_busy), .opDone (b_done), .opSPI_SClk (b_sclk),
    .opSPI_Data (b_data), .opSPI_Latch (b_latch), .ipMuxOut (1'b0), .opLocked (b_locked)
  );

  // Cycle counter for latch timestamps.
  always @(posedge clk) cyc <= cyc + 1;

  // Chip model A: sample Data on SClk rise, capture the word on LE rise.
  logic        a_sclk_p = 1'b0, a_latch_p = 1'b0, a_busy_p = 1'b0;
  logic [31:0] a_acc = '0;
  int          a_nb = 0, a_latches = 0, a_busy_cyc = 0, a_done_cyc = 0, a_busy_rises = 0;
  logic [31:0] a_words[$];
  int          a_bits[$];
  always @(negedge clk) begin
    if (rst) begin
      a_acc = '0;
      a_nb  = 0;
    end else begin
      if (a_sclk && !a_sclk_p) begin
        a_acc = {a_acc[30:0], a_data};
        a_nb++;
      end
      if (a_latch && !a_latch_p) begin
        a_words.push_back(a_acc);
        a_bits.push_back(a_nb);
        a_nb = 0;
        a_latches++;
      end
      if (a_busy) a_busy_cyc++;
      if (a_busy && !a_busy_p) a_busy_rises++;
      if (a_done) a_done_cyc++;
    end
    a_sclk_p  = a_sclk;
    a_latch_p = a_latch;
    a_busy_p  = a_busy;
  end

  // Chip model B, plus latch timestamps and a Data-stability counter.
  logic        b_sclk_p = 1'b0, b_latch_p = 1'b0, b_data_p = 1'b0;
  logic [23:0] b_acc = '0;
  int          b_nb = 0, b_latches = 0, b_busy_cyc = 0, b_done_cyc = 0, b_unstable = 0;
  logic [23:0] b_words[$];
  int          b_bits[$];
  int          b_lt[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (b_sclk && !b_sclk_p) begin
        if (b_data !== b_data_p) b_unstable++;
        b_acc = {b_acc[22:0], b_data};
        b_nb++;
      end
      if (b_latch && !b_latch_p) begin
        b_words.push_back(b_acc);
        b_bits.push_back(b_nb);
        b_lt.push_back(cyc);
        b_nb = 0;
        b_latches++;
      end
      if (b_busy) b_busy_cyc++;
      if (b_done) b_done_cyc++;
    end
    b_sclk_p  = b_sclk;
    b_latch_p = b_latch;
    b_data_p  = b_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int n;
    n = 0;
    while (a_busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, " idle within budget"}, 64'(a_busy), 64'd0);
  endtask

  int base, lat0, busy0, done0, rises0;

  initial begin
    // ---- reset state ----
    #1;
    check("rst busy",   64'(a_busy),   64'd0);
    check("rst done",   64'(a_done),   64'd0);
    check("rst sclk",   64'(a_sclk),   64'd0);
    check("rst data",   64'(a_data),   64'd0);
    check("rst latch",  64'(a_latch),  64'd0);
    check("rst locked", 64'(a_locked), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // ---- T1: mask 81, DEADBEEF then 00000007 ----
    for (int i = 0; i < 8; i++) a_bank[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
    a_bank[7*32 +: 32] = 32'hDEAD_BEEF;
    a_bank[0*32 +: 32] = 32'h0000_0007;
    base = a_words.size(); lat0 = a_latches; busy0 = a_busy_cyc; done0 = a_done_cyc;
    a_mask = 8'h81; a_upd = 1'b1;
    tick();
    a_upd = 1'b0;
    check("t1 busy at T+1", 64'(a_busy), 64'd1);
    check("t1 first bit",   64'(a_data), 64'd1);
    check("t1 sclk low",    64'(a_sclk), 64'd0);
    wait_idle_a("t1", 1000);
    check("t1 done pulse", 64'(a_done), 64'd1);
    tick();
    check("t1 done one cycle", 64'(a_done), 64'd0);
    check("t1 latches",   64'(a_latches - lat0), 64'd2);
    check("t1 word7",     64'(a_words[base]),     64'hDEAD_BEEF);
    check("t1 word0",     64'(a_words[base + 1]), 64'h0000_0007);
    check("t1 bits w7",   64'(a_bits[base]),      64'd32);
    check("t1 bits w0",   64'(a_bits[base + 1]),  64'd32);
    check("t1 busy cyc",  64'(a_busy_cyc - busy0), 64'd268);
    check("t1 done cyc",  64'(a_done_cyc - done0), 64'd1);

    // ---- T2: zero mask is ignored ----
    lat0 = a_latches; busy0 = a_busy_cyc; done0 = a_done_cyc; rises0 = a_busy_rises;
    base = a_words.size();
    a_mask = 8'h00; a_upd = 1'b1;
    tick();
    a_upd = 1'b0;
    check("t2 busy", 64'(a_busy), 64'd0);
    repeat (20) tick();
    check("t2 no words",  64'(a_words.size() - base), 64'd0);
    check("t2 no done",   64'(a_done_cyc - done0),    64'd0);
    check("t2 no busy",   64'(a_busy_cyc - busy0),    64'd0);

    // ---- T3: two busy-time updates coalesce into one rerun ----
    for (int i = 0; i < 8; i++) a_bank[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
    base = a_words.size(); busy0 = a_busy_cyc; done0 = a_done_cyc; rises0 = a_busy_rises;
    a_mask = 8'hFF; a_upd = 1'b1;
    tick();
    a_upd = 1'b0;
    repeat (560) tick();               // inside word index 3
    a_mask = 8'h01; a_upd = 1'b1;
    tick();
    a_upd = 1'b0;
    repeat (10) tick();
    a_mask = 8'h02; a_upd = 1'b1;
    tick();
    a_upd = 1'b0;
    a_bank[1*32 +: 32] = 32'h1234_5678;
    a_bank[0*32 +: 32] = 32'h9ABC_DEF0;
    wait_idle_a("t3", 3000);
    tick();
    check("t3 word count", 64'(a_words.size() - base), 64'd10);
    for (int k = 0; k < 8; k++)
      check($sformatf("t3 word%0d", k), 64'(a_words[base + k]), 64'(32'hC0DE_0000 | 32'(7 - k)));
    check("t3 rerun w1",   64'(a_words[base + 8]), 64'h1234_5678);
    check("t3 rerun w0",   64'(a_words[base + 9]), 64'h9ABC_DEF0);
    check("t3 busy cyc",   64'(a_busy_cyc - busy0),     64'd1340);
    check("t3 busy rises", 64'(a_busy_rises - rises0),  64'd1);
    check("t3 done cyc",   64'(a_done_cyc - done0),     64'd1);

    // ---- T4: reset mid bit 17, then a clean run with MuxOut toggling ----
    a_bank[0*32 +: 32] = 32'hA5A5_5A5A;
    lat0 = a_latches;
    a_mask = 8'h01; a_upd = 1'b1;
    tick();
    a_upd = 1'b0;
    repeat (70) tick();                // second half of bit 17 (SClk high)
    check("t4 pre sclk", 64'(a_sclk), 64'd1);
    check("t4 pre data", 64'(a_data), 64'd1);
    rst = 1'b1;
    #1;
    check("t4 rst busy",  64'(a_busy),  64'd0);
    check("t4 rst sclk",  64'(a_sclk),  64'd0);
    check("t4 rst data",  64'(a_data),  64'd0);
    check("t4 rst latch", 64'(a_latch), 64'd0);
    check("t4 rst done",  64'(a_done),  64'd0);
    tick();
    rst = 1'b0;
    repeat (300) tick();
    check("t4 no latch", 64'(a_latches - lat0), 64'd0);
    check("t4 idle",     64'(a_busy), 64'd0);

    a_bank[7*32 +: 32] = 32'h8000_0001;
    a_bank[0*32 +: 32] = 32'h7FFF_FFFE;
    base = a_words.size(); busy0 = a_busy_cyc; done0 = a_done_cyc;
    a_mask = 8'h81; a_upd = 1'b1;
    tick();
    a_upd = 1'b0;
    repeat (40) tick();
    mux_in = 1'b1;
    tick();
    check("lock rise +1", 64'(a_locked), 64'd0);
    tick();
    check("lock rise +2", 64'(a_locked), 64'd1);
    repeat (5) tick();
    mux_in = 1'b0;
    tick();
    check("lock fall +1", 64'(a_locked), 64'd1);
    tick();
    check("lock fall +2", 64'(a_locked), 64'd0);
    wait_idle_a("t4", 1000);
    tick();
    check("t4 words",    64'(a_words.size() - base), 64'd2);
    check("t4 word7",    64'(a_words[base]),     64'h8000_0001);
    check("t4 word0",    64'(a_words[base + 1]), 64'h7FFF_FFFE);
    check("t4 busy cyc", 64'(a_busy_cyc - busy0), 64'd268);
    check("t4 done cyc", 64'(a_done_cyc - done0), 64'd1);

    // ---- T5: small configuration, mask 101 ----
    b_bank = {24'hABCDEF, 24'h777777, 24'h123456};
    b_mask = 3'b101; b_upd = 1'b1;
    tick();
    b_upd = 1'b0;
    check("b busy at T+1", 64'(b_busy), 64'd1);
    repeat (110) tick();
    check("b idle",        64'(b_busy), 64'd0);
    check("b latches",     64'(b_latches), 64'd2);
    check("b word2",       64'(b_words[0]), 64'hABCDEF);
    check("b word0",       64'(b_words[1]), 64'h123456);
    check("b bits",        64'(b_bits[0] + b_bits[1]), 64'd48);
    check("b period",      64'(b_lt[1] - b_lt[0]), 64'd51);
    check("b data stable", 64'(b_unstable), 64'd0);
    check("b busy cyc",    64'(b_busy_cyc), 64'd102);
    check("b done cyc",    64'(b_done_cyc), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
